// File: rtl/seven_segment_mux_driver.sv
// rtl/seven_segment_mux_driver.sv - multiplexed hex display driver with a double-buffered value.
// Optional leading-zero blanking: define SEVSEG_LEADING_ZERO_BLANK_EN.
module seven_segment_mux_driver #(
  parameter int N_DIGITS         = 4,
  parameter int REFRESH_DIV      = 50000,
  parameter int ANODE_ACTIVE_LOW = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_enable,
  input  logic                  i_load,
  input  logic [4*N_DIGITS-1:0] i_value,
  output logic [6:0]            o_segments,
  output logic [N_DIGITS-1:0]   o_anodes,
  output logic                  o_frame_done
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(N_DIGITS - 1);
  localparam logic ANODE_POL = (ANODE_ACTIVE_LOW != 0);
  localparam logic [N_DIGITS-1:0] ANODE_OFF = {N_DIGITS{ANODE_POL}};
  localparam logic [6:0] SEG_OFF = 7'b1111111;

  logic [CNT_W-1:0]      cnt;
  logic [IDX_W-1:0]      idx;
  logic [4*N_DIGITS-1:0] shadow;
  logic [4*N_DIGITS-1:0] active;
  logic                  pending;

  logic                  slot_end;
  logic                  frame_wrap;
  logic [3:0]            nib;
  logic [6:0]            seg_next;
  logic [N_DIGITS-1:0]   anode_on;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
    case (v)
      4'h0: hex_to_seg = 7'b0000001;
      4'h1: hex_to_seg = 7'b1001111;
      4'h2: hex_to_seg = 7'b0010010;
      4'h3: hex_to_seg = 7'b0000110;
      4'h4: hex_to_seg = 7'b1001100;
      4'h5: hex_to_seg = 7'b0100100;
      4'h6: hex_to_seg = 7'b0100000;
      4'h7: hex_to_seg = 7'b0001111;
      4'h8: hex_to_seg = 7'b0000000;
      4'h9: hex_to_seg = 7'b0000100;
      4'hA: hex_to_seg = 7'b0000010;
      4'hB: hex_to_seg = 7'b1100000;
      4'hC: hex_to_seg = 7'b0110001;
      4'hD: hex_to_seg = 7'b1000010;
      4'hE: hex_to_seg = 7'b0110000;
      default: hex_to_seg = 7'b0111000;
    endcase
  endfunction

  assign slot_end   = i_enable && (cnt == CNT_MAX);
  assign frame_wrap = slot_end && (idx == IDX_MAX);

`ifdef SEVSEG_LEADING_ZERO_BLANK_EN
  logic nz_at_or_above;
`endif

  always_comb begin
    nib      = '0;
    anode_on = ANODE_OFF;
`ifdef SEVSEG_LEADING_ZERO_BLANK_EN
    nz_at_or_above = 1'b0;
`endif
    for (int k = 0; k < N_DIGITS; k++) begin
      if (IDX_W'(k) == idx) begin
        nib         = active[4*k +: 4];
        anode_on[k] = ~ANODE_POL;
      end
`ifdef SEVSEG_LEADING_ZERO_BLANK_EN
      if ((IDX_W'(k) >= idx) && (active[4*k +: 4] != 4'h0)) nz_at_or_above = 1'b1;
`endif
    end
    seg_next = hex_to_seg(nib);
`ifdef SEVSEG_LEADING_ZERO_BLANK_EN
    // Digit 0 always shows, so a value of zero still reads "0".
    if ((idx != '0) && !nz_at_or_above) seg_next = SEG_OFF;
`endif
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt          <= '0;
      idx          <= '0;
      shadow       <= '0;
      active       <= '0;
      pending      <= 1'b0;
      o_segments   <= SEG_OFF;
      o_anodes     <= ANODE_OFF;
      o_frame_done <= 1'b0;
    end else begin
      if (i_enable) begin
        if (slot_end) begin
          cnt <= '0;
          idx <= (idx == IDX_MAX) ? '0 : idx + 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end

      // A load that cannot tear a visible frame goes straight to the active buffer.
      if (i_load && (frame_wrap || !i_enable)) begin
        active  <= i_value;
        pending <= 1'b0;
      end else if (i_load) begin
        shadow  <= i_value;
        pending <= 1'b1;
      end else if (frame_wrap && pending) begin
        active  <= shadow;
        pending <= 1'b0;
      end

      o_frame_done <= frame_wrap;
      o_segments   <= i_enable ? seg_next : SEG_OFF;
      o_anodes     <= i_enable ? anode_on : ANODE_OFF;
    end
  end

endmodule

// File: doc/seven_segment_mux_driver.md
SEVEN_SEGMENT_MUX_DRIVER -- requirements
Module: seven_segment_mux_driver

Interface
REQ-001 SHALL have parameter N_DIGITS, default 4, meaning the number of multiplexed hex digits (legal range 1..8).
REQ-002 SHALL have parameter REFRESH_DIV, default 50000, meaning clock cycles each digit stays lit (legal range >= 2).
REQ-003 SHALL have parameter ANODE_ACTIVE_LOW, default 1, meaning 1 = active-low digit enables, 0 = active-high digit enables.
REQ-004 SHALL have port i_clk  input  1  the single clock; all logic is on its rising edge.
REQ-005 SHALL have port i_rst  input  1  reset; synchronous and active-high.
REQ-006 SHALL have port i_enable  input  1  display on when 1; blank and refresh frozen when 0.
REQ-007 SHALL have port i_load  input  1  single-cycle strobe that captures i_value.
REQ-008 SHALL have port i_value  input  4*N_DIGITS  hex nibbles; bits [3:0] are digit 0, the least-significant, rightmost digit.
REQ-009 SHALL have port o_segments  output  7  segments a..g on bits 6..0, active-low (0 = lit).
REQ-010 SHALL have port o_anodes  output  N_DIGITS  digit enables; bit k selects digit k.
REQ-011 SHALL have port o_frame_done  output  1  one-cycle pulse at the end of each full scan.

Function
REQ-012 SHALL decode nibbles 0..F to o_segments as 0000001, 1001111, 0010010, 0000110, 1001100, 0100100, 0100000, 0001111, 0000000, 0000100, 0000010, 1100000, 0110001, 1000010, 0110000, 0111000.
REQ-013 SHALL keep a prescale counter cnt (0..REFRESH_DIV-1) and a digit index idx (0..N_DIGITS-1), both advancing only while i_enable=1.
REQ-014 SHALL treat cnt==REFRESH_DIV-1 with i_enable=1 as the slot end: cnt returns to 0, and idx increments, wrapping from N_DIGITS-1 to 0.
REQ-015 SHALL register all outputs, so o_segments and o_anodes reflect idx and the active buffer with one cycle of latency.
REQ-016 SHALL assert exactly one o_anodes bit (bit idx, at the configured polarity) while enabled, and deassert all bits while i_enable=0.
REQ-017 SHALL drive o_segments to 1111111 (all off) while i_enable=0.
REQ-018 SHALL double-buffer the displayed value: i_load writes a shadow register and sets a pending flag; no displayed digit changes mid-frame.
REQ-019 SHALL copy shadow to active and clear pending at the frame wrap, i.e. the slot end with idx==N_DIGITS-1.
REQ-020 SHALL write i_value straight to active, leaving pending clear, when i_load coincides with a frame wrap or occurs while i_enable=0.
REQ-021 SHALL let a later i_load overwrite an earlier one still pending; only the last value loaded is displayed.
REQ-022 SHALL pulse o_frame_done high for one cycle on the cycle after each frame wrap.
REQ-023 SHALL, when N_DIGITS=1, hold idx at 0 and pulse o_frame_done every REFRESH_DIV enabled cycles.
REQ-024 SHALL hold cnt and idx when i_enable deasserts, and resume from those values when it reasserts.

Reset
REQ-025 SHALL, on the cycle after i_rst=1, clear cnt, idx, shadow, active and pending to 0.
REQ-026 SHALL, on the cycle after i_rst=1, drive o_segments=1111111, o_anodes all inactive and o_frame_done=0.
REQ-027 SHALL give i_rst priority over i_load and i_enable, including reset asserted mid-frame.

Configuration
REQ-028 SHALL implement leading-zero blanking when macro SEVSEG_LEADING_ZERO_BLANK_EN is defined: any digit k>0 whose nibble and all higher nibbles are zero outputs 1111111 while its anode is still scanned.
REQ-029 SHALL, without SEVSEG_LEADING_ZERO_BLANK_EN, display every digit per REQ-012, with zeros shown as 0000001.

Verification (all scenarios use N_DIGITS=4, REFRESH_DIV=4, ANODE_ACTIVE_LOW=1)
REQ-030 SHALL check scan order: reset, load 16'h1234 with i_enable=0, then set i_enable=1 -> o_anodes/o_segments = 1110/1001100 for 4 cycles, then 1101/0000110, 1011/0010010, 0111/1001111, then o_frame_done pulses once and the scan repeats.
REQ-031 SHALL check buffer timing: load 16'hABCD during digit 1 -> digits 2 and 3 still show 2 and 1; after o_frame_done, digit 0 shows 1000010.
REQ-032 SHALL check the coincident load: i_load with 16'hFFFF on the frame-wrap cycle -> the very next digit-0 slot shows 0111000 and pending stays 0.
REQ-033 SHALL check disable and reset: drop i_enable mid-slot -> next cycle o_anodes=1111, o_segments=1111111, and the scan resumes at the same cnt and idx; assert i_rst mid-frame -> next cycle all outputs are at reset values.
REQ-034 SHALL check the macro: load 16'h0007 -> with SEVSEG_LEADING_ZERO_BLANK_EN, digits 1-3 show 1111111 and digit 0 shows 0001111; without it, digits 1-3 show 0000001.
